// File: rtl/fp_vector_checker.sv
// Test-vector sequencer/checker for FP add/sub units: streams vectors from a sync RAM
// into the unit under test and compares its result/flags after a fixed latency.
module fp_vector_checker #(
    parameter int WIDTH     = 64,
    parameter int DEPTH     = 1024,
    parameter int LAT       = 0,
    parameter int FLAGW     = 5,
    parameter bit NAN_LOOSE = 1'b1,
    parameter int AW        = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [AW:0]          num_vec,
    input  logic [2:0]           rm_cfg,
    input  logic [2:0]           op_type_cfg,
    input  logic                 chk_flags,
    output logic [AW-1:0]        vec_addr,
    output logic                 vec_rd,
    input  logic [3*WIDTH+7:0]   vec_data,
    output logic [WIDTH-1:0]     dut_op1,
    output logic [WIDTH-1:0]     dut_op2,
    output logic [2:0]           dut_rm,
    output logic [2:0]           dut_op_type,
    output logic                 dut_valid,
    input  logic [WIDTH-1:0]     dut_result,
    input  logic [FLAGW-1:0]     dut_flags,
    output logic                 busy,
    output logic                 done,
    output logic                 err_pulse,
    output logic [AW-1:0]        err_idx,
    output logic [31:0]          err_count,
    output logic [AW-1:0]        first_err_idx
);
    localparam int EW = (WIDTH == 16) ? 5 : (WIDTH == 32) ? 8 : 11;
    localparam int FW = WIDTH - 1 - EW;
    localparam int DW = 3 * WIDTH + 8;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t             state;
    logic [AW-1:0]      last_idx_q;
    logic               rd_d1;
    logic [AW-1:0]      idx_d1;
    logic [LAT:0]       exp_v;
    logic [AW-1:0]      exp_idx [LAT+1];
    logic [WIDTH-1:0]   exp_y   [LAT+1];
    logic [FLAGW-1:0]   exp_f   [LAT+1];

    function automatic logic is_nan(input logic [WIDTH-1:0] x);
        return (&x[WIDTH-2 -: EW]) && (|x[FW-1:0]);
    endfunction

    logic res_ok, flags_ok, cmp_valid, cmp_err, cmp_last;
    assign res_ok    = (dut_result == exp_y[LAT]) ||
                       (NAN_LOOSE && is_nan(dut_result) && is_nan(exp_y[LAT]));
    assign flags_ok  = !chk_flags || (dut_flags == exp_f[LAT]);
    assign cmp_valid = exp_v[LAT];
    assign cmp_err   = !(res_ok && flags_ok);
    assign cmp_last  = (exp_idx[LAT] == last_idx_q);

    if (FLAGW < 8) begin : g_flag_pad
        logic unused_flag_bits;
        assign unused_flag_bits = |vec_data[7:FLAGW];
    end

    // Sequencer FSM plus error bookkeeping; everything is a registered output.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            vec_rd        <= 1'b0;
            vec_addr      <= '0;
            last_idx_q    <= '0;
            dut_rm        <= '0;
            dut_op_type   <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err_pulse     <= 1'b0;
            err_idx       <= '0;
            err_count     <= '0;
            first_err_idx <= '0;
        end else if (abort) begin
            state     <= IDLE;
            vec_rd    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err_pulse <= 1'b0;
        end else begin
            done      <= 1'b0;
            err_pulse <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    err_count     <= '0;
                    first_err_idx <= '0;
                    dut_rm        <= rm_cfg;
                    dut_op_type   <= op_type_cfg;
                    last_idx_q    <= AW'(num_vec - 1);
                    vec_addr      <= '0;
                    if (num_vec == '0) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state  <= ISSUE;
                        vec_rd <= 1'b1;
                        busy   <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (vec_addr == last_idx_q) begin
                        vec_rd <= 1'b0;
                        state  <= DRAIN;
                    end else begin
                        vec_addr <= vec_addr + AW'(1);
                    end
                end
                DRAIN: if (cmp_valid && cmp_last) begin
                    state <= DONE;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
            if (cmp_valid && cmp_err) begin
                err_pulse <= 1'b1;
                err_idx   <= exp_idx[LAT];
                if (err_count != '1)
                    err_count <= err_count + 32'd1;
                if (err_count == '0)
                    first_err_idx <= exp_idx[LAT];
            end
        end
    end

    // Valid bits of the operand register and expected delay line.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_d1     <= 1'b0;
            dut_valid <= 1'b0;
            exp_v     <= '0;
            dut_op1   <= '0;
            dut_op2   <= '0;
        end else if (abort) begin
            rd_d1     <= 1'b0;
            dut_valid <= 1'b0;
            exp_v     <= '0;
        end else begin
            rd_d1     <= vec_rd;
            dut_valid <= rd_d1;
            exp_v[0]  <= rd_d1;
            for (int i = 1; i <= LAT; i++)
                exp_v[i] <= exp_v[i-1];
            if (rd_d1) begin
                dut_op1 <= vec_data[DW-1 -: WIDTH];
                dut_op2 <= vec_data[2*WIDTH+7 -: WIDTH];
            end
        end
    end

    // NOTE: payload stages carry no reset; they are only ever consumed under exp_v.
    always_ff @(posedge clk) begin
        idx_d1     <= vec_addr;
        exp_idx[0] <= idx_d1;
        exp_y[0]   <= vec_data[WIDTH+7 -: WIDTH];
        exp_f[0]   <= vec_data[FLAGW-1:0];
        for (int i = 1; i <= LAT; i++) begin
            exp_idx[i] <= exp_idx[i-1];
            exp_y[i]   <= exp_y[i-1];
            exp_f[i]   <= exp_f[i-1];
        end
    end
endmodule

// File: tb/tb_fp_vector_checker.sv
// Bench for fp_vector_checker: two instances (LAT=0 loose-NaN, LAT=3 strict-NaN)
// share stimulus; vector RAM and a stand-in arithmetic unit live in the bench.
module tb_fp_vector_checker;
    localparam int W = 64, DEPTH = 64, AW = 6, FLAGW = 5, DW = 3*W+8;

    logic clk = 1'b0;
    logic reset_n, start, abort, chk_flags;
    logic [AW:0] num_vec;
    logic [2:0]  rm_cfg, op_type_cfg;

    logic [AW-1:0] vec_addr0, vec_addr3, err_idx0, err_idx3, first0, first3;
    logic vec_rd0, vec_rd3, dut_valid0, dut_valid3, busy0, busy3, done0, done3;
    logic err_pulse0, err_pulse3;
    logic [DW-1:0] vec_data0, vec_data3;
    logic [W-1:0] op1_0, op2_0, op1_3, op2_3, res0, res3;
    logic [FLAGW-1:0] flg0, flg3;
    logic [2:0] rm0, rm3, opt0, opt3;
    logic [31:0] cnt0, cnt3;

    logic [W-1:0] mem_op1 [DEPTH];
    logic [W-1:0] mem_op2 [DEPTH];
    logic [W-1:0] mem_y   [DEPTH];
    logic [7:0]   mem_f   [DEPTH];

    int n_checks = 0, n_errs = 0;

    always #5 clk = ~clk;

    fp_vector_checker #(.WIDTH(W), .DEPTH(DEPTH), .LAT(0), .FLAGW(FLAGW), .NAN_LOOSE(1'b1)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .num_vec(num_vec),
        .rm_cfg(rm_cfg), .op_type_cfg(op_type_cfg), .chk_flags(chk_flags),
        .vec_addr(vec_addr0), .vec_rd(vec_rd0), .vec_data(vec_data0),
        .dut_op1(op1_0), .dut_op2(op2_0), .dut_rm(rm0), .dut_op_type(opt0), .dut_valid(dut_valid0),
        .dut_result(res0), .dut_flags(flg0), .busy(busy0), .done(done0), .err_pulse(err_pulse0),
        .err_idx(err_idx0), .err_count(cnt0), .first_err_idx(first0));

    fp_vector_checker #(.WIDTH(W), .DEPTH(DEPTH), .LAT(3), .FLAGW(FLAGW), .NAN_LOOSE(1'b0)) u_dut3 (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .num_vec(num_vec),
        .rm_cfg(rm_cfg), .op_type_cfg(op_type_cfg), .chk_flags(chk_flags),
        .vec_addr(vec_addr3), .vec_rd(vec_rd3), .vec_data(vec_data3),
        .dut_op1(op1_3), .dut_op2(op2_3), .dut_rm(rm3), .dut_op_type(opt3), .dut_valid(dut_valid3),
        .dut_result(res3), .dut_flags(flg3), .busy(busy3), .done(done3), .err_pulse(err_pulse3),
        .err_idx(err_idx3), .err_count(cnt3), .first_err_idx(first3));

    // Stand-in arithmetic unit: plain integer sum, flags from operand bits.
    function automatic logic [W-1:0] f_res(input logic [W-1:0] a, input logic [W-1:0] b);
        return a + b;
    endfunction
    function automatic logic [4:0] f_flg(input logic [W-1:0] a, input logic [W-1:0] b);
        return a[4:0] ^ b[9:5];
    endfunction
    function automatic bit is_nan64(input logic [63:0] x);
        return (x[62:52] == 11'h7FF) && (x[51:0] != 52'd0);
    endfunction

    always @(posedge clk) begin
        if (vec_rd0) vec_data0 <= {mem_op1[vec_addr0], mem_op2[vec_addr0], mem_y[vec_addr0], mem_f[vec_addr0]};
        if (vec_rd3) vec_data3 <= {mem_op1[vec_addr3], mem_op2[vec_addr3], mem_y[vec_addr3], mem_f[vec_addr3]};
    end

    assign res0 = f_res(op1_0, op2_0);
    assign flg0 = f_flg(op1_0, op2_0);
    logic [W+4:0] p3 [3];
    always @(posedge clk) begin
        p3[0] <= {f_res(op1_3, op2_3), f_flg(op1_3, op2_3)};
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign {res3, flg3} = p3[2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic bit outs_nonzero0();
        return |{vec_rd0, vec_addr0, op1_0, op2_0, rm0, opt0, dut_valid0, busy0, done0,
                 err_pulse0, err_idx0, cnt0, first0};
    endfunction
    function automatic bit outs_nonzero3();
        return |{vec_rd3, vec_addr3, op1_3, op2_3, rm3, opt3, dut_valid3, busy3, done3,
                 err_pulse3, err_idx3, cnt3, first3};
    endfunction

    task automatic fill_rand(input bit with_nan);
        for (int k = 0; k < DEPTH; k++) begin
            logic [63:0] a, b, fr;
            a = {4'h0, 28'($urandom), 32'($urandom)};
            b = {4'h0, 28'($urandom), 32'($urandom)};
            mem_op1[k] = a;
            mem_op2[k] = b;
            mem_y[k]   = a + b;
            mem_f[k]   = {3'($urandom), f_flg(a, b)};
            if (with_nan && $urandom_range(0, 7) == 0) begin
                fr = {$urandom, $urandom};
                mem_op1[k] = {1'($urandom), 11'h7FF, fr[51:1], 1'b1};
                mem_op2[k] = 64'd0;
                fr = {$urandom, $urandom};
                mem_y[k] = {1'($urandom), 11'h7FF, fr[51:1], 1'b1};
                mem_f[k][4:0] = f_flg(mem_op1[k], 64'd0);
            end
        end
    endtask

    // Observations from the most recent run.
    int done_cyc0, done_cyc3, rd_cnt, addr_bad;
    int p0[$], p3q[$];
    logic [2:0] seen_rm0, seen_rm3, seen_opt0, seen_opt3;
    bit busy_at1, busy_at_done;

    task automatic do_run(input int n, input bit chk, input logic [2:0] rm, input logic [2:0] opt);
        done_cyc0 = -1; done_cyc3 = -1; rd_cnt = 0; addr_bad = 0;
        p0.delete(); p3q.delete();
        busy_at1 = 1'b0; busy_at_done = 1'b0;
        @(negedge clk);
        num_vec = (AW+1)'(n); chk_flags = chk; rm_cfg = rm; op_type_cfg = opt; start = 1'b1;
        for (int cyc = 1; cyc <= n + 10; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                start = 1'b0; rm_cfg = ~rm; op_type_cfg = ~opt;
                busy_at1 = busy0;
            end
            if (cyc == 2) begin
                seen_rm0 = rm0; seen_rm3 = rm3; seen_opt0 = opt0; seen_opt3 = opt3;
            end
            if (vec_rd0) begin
                if (int'(vec_addr0) != rd_cnt || vec_addr3 != vec_addr0) addr_bad++;
                rd_cnt++;
            end
            if (err_pulse0) p0.push_back(cyc * 256 + int'(err_idx0));
            if (err_pulse3) p3q.push_back(cyc * 256 + int'(err_idx3));
            if (done0 && done_cyc0 < 0) begin done_cyc0 = cyc; busy_at_done = busy0; end
            if (done3 && done_cyc3 < 0) done_cyc3 = cyc;
        end
    endtask

    // Reference: per-vector match decided from the stored vector and the unit's function,
    // events placed by index arithmetic (address k issued in cycle k+1 after the start edge).
    task automatic check_run(input int n, input bit chk, input logic [2:0] rm, input logic [2:0] opt);
        check("rd_count", rd_cnt, n);
        check("addr_seq", addr_bad, 0);
        check("busy_after_start", busy_at1, n != 0);
        check("busy_low_at_done", busy_at_done, 0);
        check("rm_latched", {seen_rm0, seen_rm3}, {rm, rm});
        check("op_latched", {seen_opt0, seen_opt3}, {opt, opt});
        for (int d = 0; d < 2; d++) begin
            int lat, ecnt, efirst, obs_cnt, obs_first, obs_done;
            bit loose, ok;
            int expq[$], obs[$];
            lat = (d == 0) ? 0 : 3;
            loose = (d == 0);
            ecnt = 0; efirst = 0;
            for (int k = 0; k < n; k++) begin
                logic [63:0] r;
                bit same;
                r = mem_op1[k] + mem_op2[k];
                same = (r == mem_y[k]) || (loose && is_nan64(r) && is_nan64(mem_y[k]));
                if (!same || (chk && f_flg(mem_op1[k], mem_op2[k]) != mem_f[k][4:0])) begin
                    if (ecnt == 0) efirst = k;
                    ecnt++;
                    expq.push_back((k + 4 + lat) * 256 + k);
                end
            end
            obs       = (d == 0) ? p0 : p3q;
            obs_cnt   = (d == 0) ? int'(cnt0) : int'(cnt3);
            obs_first = (d == 0) ? int'(first0) : int'(first3);
            obs_done  = (d == 0) ? done_cyc0 : done_cyc3;
            ok = (obs.size() == expq.size());
            if (ok) foreach (expq[i]) if (obs[i] != expq[i]) ok = 1'b0;
            check($sformatf("done_cycle_lat%0d", lat), obs_done, (n == 0) ? 1 : n + 3 + lat);
            check($sformatf("pulse_count_lat%0d", lat), obs.size(), expq.size());
            check($sformatf("pulse_seq_lat%0d", lat), ok, 1);
            check($sformatf("err_count_lat%0d", lat), obs_cnt, ecnt);
            check($sformatf("first_err_lat%0d", lat), obs_first, efirst);
        end
    endtask

    typedef struct {
        int n; bit chk; logic [2:0] rm; logic [2:0] opt;
        logic [31:0] ybad; logic [31:0] fbad; int ecnt; int efirst;
    } vec_t;

    initial begin
        vec_t tbl [6];
        int n;
        bit chk;
        logic [2:0] rm, opt;

        tbl[0] = '{4, 1'b1, 3'd0, 3'd1, 32'h0,  32'h0, 0, 0};
        tbl[1] = '{5, 1'b1, 3'd1, 3'd0, 32'h4,  32'h0, 1, 2};
        tbl[2] = '{8, 1'b1, 3'd2, 3'd0, 32'h81, 32'h0, 2, 0};
        tbl[3] = '{4, 1'b0, 3'd3, 3'd1, 32'h0,  32'h2, 0, 0};
        tbl[4] = '{4, 1'b1, 3'd4, 3'd1, 32'h0,  32'h2, 1, 1};
        tbl[5] = '{0, 1'b1, 3'd5, 3'd1, 32'h0,  32'h0, 0, 0};

        reset_n = 1'b0; start = 1'b0; abort = 1'b0; chk_flags = 1'b0;
        num_vec = '0; rm_cfg = '0; op_type_cfg = '0;
        fill_rand(1'b0);
        repeat (3) @(negedge clk);
        check("reset_outs0", outs_nonzero0(), 0);
        check("reset_outs3", outs_nonzero3(), 0);
        reset_n = 1'b1;
        @(negedge clk);
        check("idle_after_reset", outs_nonzero0() | outs_nonzero3(), 0);

        foreach (tbl[i]) begin
            fill_rand(1'b0);
            for (int k = 0; k < 32; k++) begin
                if (tbl[i].ybad[k]) mem_y[k] = mem_y[k] + 64'd1;
                if (tbl[i].fbad[k]) mem_f[k][0] = ~mem_f[k][0];
            end
            do_run(tbl[i].n, tbl[i].chk, tbl[i].rm, tbl[i].opt);
            check($sformatf("tbl%0d_cnt0", i), cnt0, tbl[i].ecnt);
            check($sformatf("tbl%0d_cnt3", i), cnt3, tbl[i].ecnt);
            check($sformatf("tbl%0d_first0", i), first0, tbl[i].efirst);
            check_run(tbl[i].n, tbl[i].chk, tbl[i].rm, tbl[i].opt);
        end

        // Differently-encoded NaNs: loose instance matches, strict instance flags it.
        fill_rand(1'b0);
        mem_op1[0] = 64'hFFF0_0000_0000_0001;
        mem_op2[0] = 64'd0;
        mem_y[0]   = 64'h7FF8_0000_0000_0000;
        mem_f[0]   = {3'b0, f_flg(mem_op1[0], 64'd0)};
        do_run(1, 1'b1, 3'd0, 3'd0);
        check("nan_loose_cnt", cnt0, 0);
        check("nan_strict_cnt", cnt3, 1);
        check_run(1, 1'b1, 3'd0, 3'd0);

        for (int r = 0; r < 8; r++) begin
            fill_rand(1'b1);
            n = $urandom_range(1, 40);
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(0, 3) == 0) mem_y[k] = mem_y[k] + 64'd1;
                if ($urandom_range(0, 3) == 0) mem_f[k][0] = ~mem_f[k][0];
            end
            chk = 1'($urandom); rm = 3'($urandom); opt = 3'($urandom_range(0, 1));
            do_run(n, chk, rm, opt);
            check_run(n, chk, rm, opt);
        end

        // Abort while vector 3 of 10 is being issued.
        begin
            int ab_cyc, late, dones;
            ab_cyc = -1; late = 0; dones = 0;
            fill_rand(1'b0);
            mem_y[0] = mem_y[0] + 64'd1;
            mem_y[2] = mem_y[2] + 64'd1;
            @(negedge clk);
            num_vec = 7'd10; chk_flags = 1'b1; start = 1'b1;
            for (int cyc = 1; cyc <= 30; cyc++) begin
                @(negedge clk);
                if (cyc == 1) start = 1'b0;
                if (abort) begin
                    abort = 1'b0;
                    check("abort_busy", busy0 | busy3, 0);
                    check("abort_rd_valid", vec_rd0 | vec_rd3 | dut_valid0 | dut_valid3, 0);
                end else if (ab_cyc < 0 && vec_rd0 && vec_addr0 == 6'd3) begin
                    abort = 1'b1;
                    ab_cyc = cyc;
                end
                if (ab_cyc >= 0 && cyc > ab_cyc && (err_pulse0 | err_pulse3)) late++;
                if (done0 | done3) dones++;
            end
            check("abort_cycle", ab_cyc, 4);
            check("abort_no_late_pulse", late, 0);
            check("abort_no_done", dones, 0);
            check("abort_cnt0_held", cnt0, 1);
            check("abort_cnt3_flushed", cnt3, 0);
            check("abort_first0", first0, 0);

            // start together with abort is ignored, so the counts survive.
            @(negedge clk);
            start = 1'b1; abort = 1'b1; num_vec = 7'd5;
            @(negedge clk);
            start = 1'b0; abort = 1'b0;
            dones = 0;
            for (int cyc = 0; cyc < 4; cyc++) begin
                if (busy0 | busy3 | vec_rd0 | vec_rd3 | done0 | done3) dones++;
                @(negedge clk);
            end
            check("start_abort_idle", dones, 0);
            check("start_abort_cnt_kept", cnt0, 1);
        end

        // Asynchronous reset in the middle of a run.
        fill_rand(1'b0);
        mem_y[0] = mem_y[0] + 64'd1;
        @(negedge clk);
        num_vec = 7'd10; chk_flags = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_reset_cnt0", cnt0, 1);
        reset_n = 1'b0;
        #1;
        check("midrun_reset_outs0", outs_nonzero0(), 0);
        check("midrun_reset_outs3", outs_nonzero3(), 0);
        @(negedge clk);
        reset_n = 1'b1;
        begin
            int act;
            act = 0;
            repeat (15) begin
                @(negedge clk);
                if (outs_nonzero0() | outs_nonzero3()) act++;
            end
            check("post_reset_quiet", act, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
